color_reduce_ctrl: RTL
======================

// Module: color_reduce_ctrl
// PURPOSE
//  Sequences threshold configuration for the HSV color-reduction pipeline (rgb2hsv -> colorReduction -> hsv2rgb).
//  Captures user edits into shadow registers; commits them to the live H/S/V thresholds only at a frame
//  boundary (rising vsync_in), so no frame is reduced with mixed masks.
//  Also delays pix_valid/hsync/vsync by the pipeline latency so the syncs stay aligned with tRGB.
// PARAMETERS
//  PIPE_LAT   3       clocks from RGB in to tRGB out; depth of sync delay line (>=1)
//  H_RST      8'hF0   reset value of shadow and live hThreshold
//  S_RST      8'hE0   reset value of shadow and live sThreshold
//  V_RST      8'hE0   reset value of shadow and live vThreshold
// PORTS
//  clk            in   1  system clock
//  reset          in   1  synchronous, active-low reset
//  select         in   1  debounced button level; rising edge = write request
//  selector       in   2  target: 0=H, 1=S, 2=V, 3=bypass toggle (see CONFIGURATION)
//  inputVal       in   3  number of LSBs to clear; mask = 8'hFF << inputVal
//  pix_valid_in   in   1  pixel valid aligned with RGB input
//  hsync_in       in   1  hsync aligned with RGB input
//  vsync_in       in   1  vsync aligned with RGB input; rising edge = frame boundary
//  hThreshold     out  8  live H mask to colorReduction
//  sThreshold     out  8  live S mask
//  vThreshold     out  8  live V mask
//  pending        out  1  shadow differs from live; a commit is armed
//  pix_valid_out  out  1  pix_valid_in delayed PIPE_LAT clocks
//  hsync_out      out  1  hsync_in delayed PIPE_LAT clocks
//  vsync_out      out  1  vsync_in delayed PIPE_LAT clocks
// BEHAVIOUR
//  Reset (reset==0 at clk edge): state=IDLE; shadow and live = H_RST/S_RST/V_RST; pending=0;
//   edge-detect regs=0; delay line all 0, so the *_out ports are 0 for PIPE_LAT clocks after release.
//  Reset mid-frame or mid-commit: discards all pending edits. No partial commit.
//  sel_rise = select & ~select_q; vs_rise = vsync_in & ~vsync_q (both _q registered).
//  Shadow write on sel_rise, selector 0..2: shadow[selector] <= 8'hFF << inputVal. inputVal=0 -> 8'hFF.
//   inputVal=7 -> 8'h80.
//  FSM:
//   IDLE   : sel_rise -> ARMED (the shadow write occurs on the same edge).
//   ARMED  : sel_rise -> shadow write, stay ARMED (last write wins). vs_rise -> COMMIT.
//            sel_rise and vs_rise together -> the write lands in shadow and the FSM goes to COMMIT;
//            that edit is included in the commit.
//   COMMIT : live <= shadow; -> IDLE. A sel_rise here writes shadow and goes to ARMED;
//            that edit waits for the next frame.
//  vs_rise in IDLE: no effect. sel_rise and vs_rise together in IDLE: go to ARMED; commit at the next frame.
//  Latency: live outputs change 2 clocks after the edge where vsync_in is first sampled high.
//  pending = (state != IDLE); it deasserts on the same edge that loads live.
//  Delay line: a PIPE_LAT-deep shift register of {pix_valid, hsync, vsync}. It has no enable and never stalls.
//  All outputs are registered; there are no combinational paths from inputs to outputs.
// CONFIGURATION
//  Macro COLOR_REDUCE_BYPASS_EN.
//  Defined: a bypass flag is added, reset 0. sel_rise with selector==3 toggles the shadow bypass and arms
//   a commit like any other write. Live bypass=1 forces all three threshold outputs to 8'hFF;
//   the stored masks are preserved.
//  Undefined: selector==3 is ignored (no shadow write, no state change); outputs are always the live masks.
// STRUCTURE
//  Shared package color_reduce_pkg: FSM state encodings (IDLE/ARMED/COMMIT),
//   selector codes (SEL_H/SEL_S/SEL_V/SEL_BYP), mask width constant (8).
//  One sub-module: sync_delay_line (parameter DEPTH, WIDTH=3), holding the valid/sync shift register.
//  The FSM and the shadow/live register banks stay in color_reduce_ctrl.
// TESTING
//  1. Reset, release -> h/s/vThreshold = F0/E0/E0, pending=0, *_out=0 for 3 clocks.
//  2. selector=0, inputVal=2, pulse select -> pending=1, hThreshold stays F0;
//     vsync_in rises -> hThreshold=FC exactly 2 clocks later, pending=0.
//  3. In ARMED: write S with inputVal=5, then S with inputVal=1 -> after vsync rise, sThreshold=FE (last wins).
//  4. sel_rise (V, inputVal=7) on the same edge as vs_rise in ARMED -> vThreshold=80 after commit;
//     the same coincidence in IDLE -> no change until the following vsync rise.
//  5. Toggle pix_valid/hsync/vsync patterns -> outputs equal inputs delayed exactly 3 clocks;
//     assert reset while ARMED -> masks return to F0/E0/E0, pending=0.
//  6. With COLOR_REDUCE_BYPASS_EN: selector=3 pulse + vsync -> all outputs FF; second toggle + vsync
//     -> prior masks restored. Without the macro: selector=3 pulse -> pending stays 0.

Source files
------------

// File: rtl/color_reduce_pkg.sv
// rtl/color_reduce_pkg.sv - shared types and constants for the color reduction threshold controller
//
// Purpose: FSM state encoding, selector codes, mask width and the LSB-clear mask helper.
// Ports:   none (package).
package color_reduce_pkg;

  localparam int MASK_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] SEL_H   = 2'd0;
  localparam logic [1:0] SEL_S   = 2'd1;
  localparam logic [1:0] SEL_V   = 2'd2;
  localparam logic [1:0] SEL_BYP = 2'd3;

  // Mask that clears the n least significant bits of a threshold.
  function automatic logic [MASK_W-1:0] lsb_clear_mask(input logic [2:0] n);
    logic [MASK_W-1:0] ones;
    ones = '1;
    return ones << n;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - fixed-depth shift register aligning valid/sync with the pixel pipeline
//
// Purpose: delays a WIDTH-bit bundle by exactly DEPTH clocks; no enable, never stalls.
// Ports:
//   clk   in           system clock
//   reset in           synchronous, active-low; clears every stage
//   din   in  [WIDTH]  bundle entering the pipeline
//   dout  out [WIDTH]  bundle delayed DEPTH clocks (registered)
module sync_delay_line #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/color_reduce_ctrl.sv
// rtl/color_reduce_ctrl.sv - frame-synchronous H/S/V threshold sequencer with sync delay line
//
// Purpose: captures mask edits into shadow registers and commits them to the live thresholds
//   only at a frame boundary (rising vsync_in); delays pix_valid/hsync/vsync by PIPE_LAT.
// Optional feature: macro COLOR_REDUCE_BYPASS_EN adds a bypass flag (selector 3) that forces
//   all live threshold outputs to 8'hFF while preserving the stored masks.
// Ports:
//   clk, reset                       clock, synchronous active-low reset
//   select, selector[1:0], inputVal  button level (rise = write), target, LSBs to clear
//   pix_valid_in, hsync_in, vsync_in syncs aligned with RGB input; vsync rise = frame boundary
//   h/s/vThreshold[7:0]              live masks to colorReduction
//   pending                          an edit is armed and not yet committed
//   pix_valid_out, hsync_out, vsync_out  syncs delayed PIPE_LAT clocks
module color_reduce_ctrl
  import color_reduce_pkg::*;
#(
  parameter int          PIPE_LAT = 3,
  parameter logic [7:0]  H_RST    = 8'hF0,
  parameter logic [7:0]  S_RST    = 8'hE0,
  parameter logic [7:0]  V_RST    = 8'hE0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       select,
  input  logic [1:0] selector,
  input  logic [2:0] inputVal,
  input  logic       pix_valid_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [7:0] hThreshold,
  output logic [7:0] sThreshold,
  output logic [7:0] vThreshold,
  output logic       pending,
  output logic       pix_valid_out,
  output logic       hsync_out,
  output logic       vsync_out
);

  // Inputs are registered once before edge detection so control decisions never depend
  // combinationally on pins; this is what places the live update 2 clocks after the edge
  // on which vsync_in is first sampled high.
  logic       select_s, select_q;
  logic       vsync_s, vsync_q;
  logic [1:0] selector_s;
  logic [2:0] inputval_s;

  always_ff @(posedge clk) begin
    if (!reset) begin
      select_s   <= 1'b0;
      select_q   <= 1'b0;
      vsync_s    <= 1'b0;
      vsync_q    <= 1'b0;
      selector_s <= '0;
      inputval_s <= '0;
    end else begin
      select_s   <= select;
      select_q   <= select_s;
      vsync_s    <= vsync_in;
      vsync_q    <= vsync_s;
      selector_s <= selector;
      inputval_s <= inputVal;
    end
  end

  logic sel_rise, vs_rise, wr;
  assign sel_rise = select_s & ~select_q;
  assign vs_rise  = vsync_s & ~vsync_q;

`ifdef COLOR_REDUCE_BYPASS_EN
  assign wr = sel_rise;
`else
  // Without the bypass feature selector 3 is inert: no shadow write and no arming.
  assign wr = sel_rise & (selector_s != SEL_BYP);
`endif

  state_t state_q, state_d;
  logic   commit;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        // A write coinciding with the frame boundary lands in shadow this edge and is
        // therefore part of the commit that follows.
        if (vs_rise) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        // live takes the pre-write shadow here; a fresh edit waits for the next frame.
        state_d = wr ? ST_ARMED : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [MASK_W-1:0] sh_h, sh_s, sh_v;
  logic [MASK_W-1:0] live_h, live_s, live_v;
  logic [MASK_W-1:0] new_mask;
  assign new_mask = lsb_clear_mask(inputval_s);

`ifdef COLOR_REDUCE_BYPASS_EN
  logic sh_byp, live_byp;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      sh_h     <= H_RST;
      sh_s     <= S_RST;
      sh_v     <= V_RST;
      live_h   <= H_RST;
      live_s   <= S_RST;
      live_v   <= V_RST;
`ifdef COLOR_REDUCE_BYPASS_EN
      sh_byp   <= 1'b0;
      live_byp <= 1'b0;
`endif
    end else begin
      if (wr) begin
        case (selector_s)
          SEL_H:   sh_h <= new_mask;
          SEL_S:   sh_s <= new_mask;
          SEL_V:   sh_v <= new_mask;
`ifdef COLOR_REDUCE_BYPASS_EN
          SEL_BYP: sh_byp <= ~sh_byp;
`endif
          default: ;
        endcase
      end
      if (commit) begin
        live_h   <= sh_h;
        live_s   <= sh_s;
        live_v   <= sh_v;
`ifdef COLOR_REDUCE_BYPASS_EN
        live_byp <= sh_byp;
`endif
      end
    end
  end

`ifdef COLOR_REDUCE_BYPASS_EN
  assign hThreshold = live_byp ? '1 : live_h;
  assign sThreshold = live_byp ? '1 : live_s;
  assign vThreshold = live_byp ? '1 : live_v;
`else
  assign hThreshold = live_h;
  assign sThreshold = live_s;
  assign vThreshold = live_v;
`endif

  assign pending = (state_q != ST_IDLE);

  logic [2:0] dly_out;

  sync_delay_line #(
    .DEPTH (PIPE_LAT),
    .WIDTH (3)
  ) u_sync_delay_line (
    .clk   (clk),
    .reset (reset),
    .din   ({pix_valid_in, hsync_in, vsync_in}),
    .dout  (dly_out)
  );

  assign pix_valid_out = dly_out[2];
  assign hsync_out     = dly_out[1];
  assign vsync_out     = dly_out[0];

endmodule
